// File: rtl/mdu_multdiv_pkg.sv
// -----------------------------------------------------------------------------
// mdu_multdiv_pkg
// Shared definitions for the multiply/divide unit:
//   - MDU_SEL_* codes for the 3-bit op select {funct[3], funct[1:0]}
//   - default per-class latencies
//   - small decode helpers (mult/div-class predicate, divide, unsigned)
// Optional feature macro used by the unit: MDU_MADD_EN (multiply-accumulate).
// -----------------------------------------------------------------------------
package mdu_multdiv_pkg;

  // Op select encodings
  localparam logic [2:0] MDU_SEL_MFHI  = 3'b000;
  localparam logic [2:0] MDU_SEL_MTHI  = 3'b001;
  localparam logic [2:0] MDU_SEL_MFLO  = 3'b010;
  localparam logic [2:0] MDU_SEL_MTLO  = 3'b011;
  localparam logic [2:0] MDU_SEL_MULT  = 3'b100;
  localparam logic [2:0] MDU_SEL_MULTU = 3'b101;
  localparam logic [2:0] MDU_SEL_DIV   = 3'b110;
  localparam logic [2:0] MDU_SEL_DIVU  = 3'b111;

  // Default latencies (cycles of busy per class)
  localparam int MDU_DEF_MULT_CYCLES = 5;
  localparam int MDU_DEF_DIV_CYCLES  = 10;

  // Operation class of a select code
  typedef enum logic [1:0] {
    MDU_CLS_MOVE = 2'd0,
    MDU_CLS_MULT = 2'd1,
    MDU_CLS_DIV  = 2'd2
  } mdu_cls_e;

  // Multi-cycle (mult/div) ops are the ones with sel[2] set.
  function automatic logic mdu_is_multdiv(input logic [2:0] sel);
    return sel[2];
  endfunction

  // Within the multi-cycle class, sel[1] picks divide, sel[0] picks unsigned.
  function automatic logic mdu_is_div(input logic [2:0] sel);
    return sel[2] & sel[1];
  endfunction

  function automatic logic mdu_is_unsigned(input logic [2:0] sel);
    return sel[0];
  endfunction

  function automatic mdu_cls_e mdu_class(input logic [2:0] sel);
    if (!sel[2])     return MDU_CLS_MOVE;
    else if (sel[1]) return MDU_CLS_DIV;
    else             return MDU_CLS_MULT;
  endfunction

endpackage

// File: rtl/mdu_latency_ctr.sv
// -----------------------------------------------------------------------------
// mdu_latency_ctr
// Down-counter that times a multi-cycle operation.
//   clk       in   clock, rising edge
//   reset_n   in   asynchronous active-low reset (clears the count)
//   load      in   start an operation: count <= load_val
//   load_val  in   number of busy cycles (>= 1)
//   busy      out  count is non-zero
//   last      out  count == 1, i.e. the final busy cycle
// load is only asserted by the parent while the counter is idle.
// -----------------------------------------------------------------------------
module mdu_latency_ctr #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          busy,
  output logic          last
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign busy = (r_cnt != '0);
  assign last = (r_cnt == CW'(1));

endmodule

// File: rtl/mdu_multdiv.sv
// -----------------------------------------------------------------------------
// mdu_multdiv
// Multi-cycle multiply/divide unit with HI/LO registers (E stage).
// The product/quotient is formed combinationally when the op starts, parked
// in a pending register, and written to HI/LO at the end of the last busy
// cycle, so the visible timing matches an iterative unit of the configured
// latency.
//
// Parameters
//   WIDTH        operand and HI/LO width
//   MULT_CYCLES  busy cycles for mult/multu (>= 1)
//   DIV_CYCLES   busy cycles for div/divu   (>= 1)
//
// Ports
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset; aborts any operation
//   req      in   E-stage instruction is mult/div-class
//   sel      in   op select (see MDU_SEL_* in mdu_multdiv_pkg)
//   flush    in   E-stage instruction cancelled; request ignored this cycle
//   accum    in   accumulate into HI/LO for mult/multu (MDU_MADD_EN only)
//   rs_val   in   forwarded rs operand
//   rt_val   in   forwarded rt operand
//   busy     out  operation in flight
//   stall    out  busy | start
//   done     out  pulse in the final busy cycle
//   hi, lo   out  HI / LO registers
//   rd       out  mfhi/mflo read value (0 for other selects)
//
// Build option: define MDU_MADD_EN to enable multiply-accumulate.
// -----------------------------------------------------------------------------
module mdu_multdiv
  import mdu_multdiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MDU_DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req,
  input  logic [2:0]       sel,
  input  logic             flush,
  input  logic             accum,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic w_busy;
  logic w_last;
  logic w_accept;
  logic w_start;
  logic w_is_div;
  logic w_unsigned;
  logic w_acc_req;

  assign w_accept   = req & ~flush & ~w_busy;
  assign w_start    = w_accept & mdu_is_multdiv(sel);
  assign w_is_div   = mdu_is_div(sel);
  assign w_unsigned = mdu_is_unsigned(sel);

`ifdef MDU_MADD_EN
  assign w_acc_req = accum;
`else
  // accum is part of the interface in every build but has no effect here.
  logic w_unused_accum;
  assign w_unused_accum = accum;
  assign w_acc_req      = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Latency counter
  // ---------------------------------------------------------------------------
  logic [CW-1:0] w_load_val;

  assign w_load_val = w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

  mdu_latency_ctr #(
    .CW (CW)
  ) u_ctr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_start),
    .load_val (w_load_val),
    .busy     (w_busy),
    .last     (w_last)
  );

  // ---------------------------------------------------------------------------
  // Multiply: extend both operands to 2*WIDTH (sign or zero) so the low
  // 2*WIDTH bits of a plain product are the correct signed/unsigned result.
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] w_mul_a;
  logic [2*WIDTH-1:0] w_mul_b;
  logic [2*WIDTH-1:0] w_product;

  assign w_mul_a   = w_unsigned ? {{WIDTH{1'b0}}, rs_val}
                                : {{WIDTH{rs_val[WIDTH-1]}}, rs_val};
  assign w_mul_b   = w_unsigned ? {{WIDTH{1'b0}}, rt_val}
                                : {{WIDTH{rt_val[WIDTH-1]}}, rt_val};
  assign w_product = w_mul_a * w_mul_b;

  // ---------------------------------------------------------------------------
  // Divide: work on magnitudes, then restore signs. The quotient is negative
  // when operand signs differ; the remainder follows the dividend.
  // ---------------------------------------------------------------------------
  logic             w_rs_neg;
  logic             w_rt_neg;
  logic [WIDTH-1:0] w_abs_rs;
  logic [WIDTH-1:0] w_abs_rt;
  logic             w_div_zero;
  logic             w_div_ovf;
  logic [WIDTH-1:0] w_divisor;
  logic [WIDTH-1:0] w_quo_mag;
  logic [WIDTH-1:0] w_rem_mag;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_rs_neg   = ~w_unsigned & rs_val[WIDTH-1];
  assign w_rt_neg   = ~w_unsigned & rt_val[WIDTH-1];
  assign w_abs_rs   = w_rs_neg ? ('0 - rs_val) : rs_val;
  assign w_abs_rt   = w_rt_neg ? ('0 - rt_val) : rt_val;
  assign w_div_zero = (rt_val == '0);
  // Most-negative / -1 does not fit; defined as lo = rs, hi = 0.
  assign w_div_ovf  = ~w_unsigned & (rs_val == {1'b1, {(WIDTH-1){1'b0}}})
                                  & (rt_val == '1);
  // Substitute 1 for a zero divisor so the divider never sees /0; the result
  // is discarded in that case anyway.
  assign w_divisor  = w_div_zero ? WIDTH'(1) : w_abs_rt;
  assign w_quo_mag  = w_abs_rs / w_divisor;
  assign w_rem_mag  = w_abs_rs % w_divisor;
  assign w_quo      = (w_rs_neg ^ w_rt_neg) ? ('0 - w_quo_mag) : w_quo_mag;
  assign w_rem      = w_rs_neg ? ('0 - w_rem_mag) : w_rem_mag;

  // ---------------------------------------------------------------------------
  // Pending result, captured at start
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] r_pend;      // {hi, lo} to commit
  logic               r_pend_wr;   // 0 on divide-by-zero: HI/LO untouched
  logic               r_pend_acc;  // add to HI/LO instead of overwriting
  logic [2*WIDTH-1:0] w_pend_next;

  always_comb begin
    w_pend_next = w_product;
    if (w_is_div) begin
      if (w_div_ovf) w_pend_next = {{WIDTH{1'b0}}, rs_val};
      else           w_pend_next = {w_rem, w_quo};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend     <= '0;
      r_pend_wr  <= 1'b0;
      r_pend_acc <= 1'b0;
    end else if (w_start) begin
      r_pend     <= w_pend_next;
      r_pend_wr  <= ~(w_is_div & w_div_zero);
      r_pend_acc <= w_acc_req & ~w_is_div;
    end
  end

  // ---------------------------------------------------------------------------
  // HI/LO registers. Commit happens only while busy and moves only while
  // idle, so the two never coincide.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             w_commit;

  assign w_commit = w_last & r_pend_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      // Accumulate reads HI/LO as they stand at commit time.
      if (r_pend_acc) {r_hi, r_lo} <= {r_hi, r_lo} + r_pend;
      else            {r_hi, r_lo} <= r_pend;
    end else if (w_accept) begin
      if (sel == MDU_SEL_MTHI) r_hi <= rs_val;
      if (sel == MDU_SEL_MTLO) r_lo <= rs_val;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    rd = '0;
    if (sel == MDU_SEL_MFHI)      rd = r_hi;
    else if (sel == MDU_SEL_MFLO) rd = r_lo;
  end

  assign busy  = w_busy;
  assign stall = w_busy | w_start;
  assign done  = w_last;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_mdu_multdiv.sv
module tb_mdu_multdiv;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic [2:0]  sel;
  logic        flush;
  logic        accum;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_multdiv dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .sel     (sel),
    .flush   (flush),
    .accum   (accum),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .rd      (rd)
  );

  typedef struct {
    string       name;
    logic [2:0]  sel;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic [2:0] s,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] eh, input logic [31:0] el);
    vec_t v;
    v.name = n; v.sel = s; v.rs = a; v.rt = b; v.exp_hi = eh; v.exp_lo = el;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one mult/div op and check its full busy/done timeline and result.
  task automatic run_op(input string name, input logic [2:0] s,
                        input logic [31:0] a, input logic [31:0] b, input logic acc,
                        input logic [31:0] eh, input logic [31:0] el);
    int n;
    n = s[1] ? 10 : 5;
    @(negedge clk);
    req = 1'b1; sel = s; rs_val = a; rt_val = b; accum = acc;
    #1;
    chk({name, " start_stall"}, 32'(stall), 32'd1);
    chk({name, " start_busy"},  32'(busy),  32'd0);
    @(negedge clk);
    // Operands change after start and must not affect the result.
    req = 1'b0; rs_val = 32'hDEAD_BEEF; rt_val = 32'h0; accum = 1'b0;
    for (int cyc = 1; cyc <= n; cyc++) begin
      chk({name, " busy"}, 32'(busy), 32'd1);
      chk({name, " done"}, 32'(done), 32'(cyc == n));
      @(negedge clk);
    end
    chk({name, " idle_busy"}, 32'(busy), 32'd0);
    chk({name, " idle_done"}, 32'(done), 32'd0);
    chk({name, " hi"}, hi, eh);
    chk({name, " lo"}, lo, el);
    $display("op %-10s rs=%h rt=%h -> hi=%h lo=%h", name, a, b, hi, lo);
  endtask

  // Single-cycle move (mthi/mtlo).
  task automatic mov(input logic [2:0] s, input logic [31:0] a);
    @(negedge clk);
    req = 1'b1; sel = s; rs_val = a;
    @(negedge clk);
    req = 1'b0;
    $display("mov sel=%b rs=%h -> hi=%h lo=%h", s, a, hi, lo);
  endtask

  initial begin
    req = 1'b0; sel = 3'b000; flush = 1'b0; accum = 1'b0;
    rs_val = '0; rt_val = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy",  32'(busy),  32'd0);
    chk("reset done",  32'(done),  32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // ---- table of mult/div vectors (hand-computed) ----
    vecs.push_back(mk("mult",     3'b100, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA));
    vecs.push_back(mk("multu",    3'b101, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA));
    vecs.push_back(mk("mult_big", 3'b100, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000));
    vecs.push_back(mk("div_n7_2", 3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD));
    vecs.push_back(mk("div_7_n2", 3'b110, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD));
    vecs.push_back(mk("div_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000));
    vecs.push_back(mk("divu",     3'b111, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E));
    vecs.push_back(mk("divu_big", 3'b111, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF));
    // Divide by zero leaves the previous (divu_big) results in place.
    vecs.push_back(mk("divu_z",   3'b111, 32'd5,         32'd0,         32'h0000_000F, 32'h0FFF_FFFF));
    vecs.push_back(mk("div_z",    3'b110, 32'hFFFF_FFFD, 32'd0,         32'h0000_000F, 32'h0FFF_FFFF));

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].sel, vecs[i].rs, vecs[i].rt, 1'b0,
             vecs[i].exp_hi, vecs[i].exp_lo);

    // ---- flushed mthi has no effect, unflushed one does ----
    @(negedge clk);
    req = 1'b1; sel = 3'b001; rs_val = 32'h1234; flush = 1'b1;
    #1 chk("flush stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("flush hi", hi, 32'h0000_000F);
    flush = 1'b0;
    @(negedge clk);
    chk("mthi hi", hi, 32'h0000_1234);
    req = 1'b0;
    $display("mthi flush/noflush -> hi=%h", hi);
    mov(3'b011, 32'h5678);
    chk("mtlo lo", lo, 32'h0000_5678);

    // ---- mfhi/mflo read in the same cycle ----
    @(negedge clk);
    req = 1'b1; sel = 3'b010; #1 chk("mflo rd", rd, 32'h0000_5678);
    sel = 3'b000;             #1 chk("mfhi rd", rd, 32'h0000_1234);
    sel = 3'b001;             #1 chk("mthi rd", rd, 32'h0);
    req = 1'b0; sel = 3'b100; #1 chk("mult rd", rd, 32'h0);
    $display("read mflo/mfhi -> lo=%h hi=%h", lo, hi);

    // ---- second mult while busy is ignored ----
    @(negedge clk);
    req = 1'b1; sel = 3'b100; rs_val = 32'd2; rt_val = 32'd3;
    #1 chk("busy2 start_stall", 32'(stall), 32'd1);
    @(negedge clk);
    rs_val = 32'd5; rt_val = 32'd7;  // req held high
    for (int cyc = 1; cyc <= 5; cyc++) begin
      chk("busy2 busy",  32'(busy),  32'd1);
      chk("busy2 stall", 32'(stall), 32'd1);
      if (cyc == 5) req = 1'b0;
      @(negedge clk);
    end
    chk("busy2 idle", 32'(busy), 32'd0);
    chk("busy2 hi", hi, 32'd0);
    chk("busy2 lo", lo, 32'd6);
    $display("mult while busy -> hi=%h lo=%h", hi, lo);

    // ---- reset mid-divide aborts with no commit ----
    @(negedge clk);
    req = 1'b1; sel = 3'b110; rs_val = 32'd100; rt_val = 32'd3;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid busy_before", 32'(busy), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("rstmid busy", 32'(busy), 32'd0);
    chk("rstmid hi", hi, 32'd0);
    chk("rstmid lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("rstmid later_busy", 32'(busy), 32'd0);
    chk("rstmid later_lo", lo, 32'd0);
    $display("reset mid-divide -> hi=%h lo=%h busy=%b", hi, lo, busy);

    // ---- multiply-accumulate ----
    mov(3'b001, 32'd0);
    mov(3'b011, 32'd10);
`ifdef MDU_MADD_EN
    run_op("madd", 3'b100, 32'd3, 32'd4, 1'b1, 32'd0, 32'd22);
`else
    run_op("madd", 3'b100, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_multdiv.md
Name: mdu_multdiv

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the E stage of the pipelined MIPS core.
- Consumes the decoder's 3-bit multiply/divide select and the is-multdiv flag, plus forwarded rs/rt operands.
- Provides a busy/stall indication to the hazard unit and the mfhi/mflo read value to the E-stage result mux.
- Generalises the previous fixed 32-bit, fixed-latency unit to configurable width and per-class latency, with defined divide-by-zero and overflow handling.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, cycles busy for mult/multu; must be >= 1.
- DIV_CYCLES, 10, cycles busy for div/divu; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  1  E-stage instruction is a mult/div-class op (ISMULTDIV).
- sel  input  3  op select, encoded {funct[3],funct[1:0]}: 000 mfhi, 001 mthi, 010 mflo, 011 mtlo, 100 mult, 101 multu, 110 div, 111 divu.
- flush  input  1  E-stage instruction is cancelled by exception/interrupt; suppresses the request this cycle.
- accum  input  1  accumulate request for mult/multu (only honoured under MDU_MADD_EN).
- rs_val  input  WIDTH  forwarded rs operand.
- rt_val  input  WIDTH  forwarded rt operand.
- busy  output  1  operation in flight.
- stall  output  1  busy | start; the hazard unit stalls D when the D instruction is mult/div-class and stall=1.
- done  output  1  one-cycle pulse in the final busy cycle.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- rd  output  WIDTH  hi when sel=000, lo when sel=010, else 0; combinational from the current registers.

Behaviour:
- Reset (async, reset_n=0): hi=lo=0, busy=0, counter=0, done=0, pending result=0. Reset during an operation aborts it; no commit occurs.
- accept = req & ~flush & ~busy; start = accept & sel[2].
- Start at edge k:
  - Latch the pending result.
  - busy is high in cycles k+1 .. k+N, where N = MULT_CYCLES (sel 10x) or DIV_CYCLES (sel 11x).
  - done is high in cycle k+N.
  - HI/LO update at the end of cycle k+N; busy is low from k+N+1.
  - Counter width is $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- mult: signed 2*WIDTH product, {hi,lo} = product. multu: unsigned.
- div: quotient truncates toward zero, lo = quotient, hi = remainder; the remainder takes the dividend's sign. divu: unsigned.
- Divide overflow (div, rs = most negative, rt = -1): lo = rs, hi = 0.
- Divide by zero (rt = 0): busy for the full DIV_CYCLES, then HI/LO are left unchanged; done still pulses.
- mthi/mtlo: when accept and sel is 001/011, hi/lo = rs_val at the next edge. No busy cycle.
- mfhi/mflo: rd is valid in the same cycle; no state change.
- req while busy is ignored (the hazard unit must stall). A flushed request has no effect. flush never cancels an in-flight operation; it commits normally.
- Operands are sampled only at start; later changes to rs_val/rt_val have no effect.
- Results may be formed at start (* and /) and held in a pending register until commit.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - accum=1 with mult/multu commits {hi,lo} = {hi,lo} + product (2*WIDTH wrap-around).
  - The accumulation uses the HI/LO values at commit time.
  - Same latency as a plain multiply.
- Undefined: the accum port is present but ignored; mult/multu overwrite HI/LO.

Decomposition:
- Shared package/header holds:
  - MDU_SEL_* constants for the eight sel codes.
  - The mult/div-class predicate (sel[2]).
  - Default latency constants.
- One natural sub-module, mdu_latency_ctr: load value, decrement, busy and last-cycle flags.

Test Plan:
- Multiply: mult rs=0xFFFFFFFE, rt=3, default parameters → busy for 5 cycles; done in the 5th; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- Signed divide: div rs=-7, rt=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide boundaries:
  - div rs=0x80000000, rt=-1 → lo=0x80000000, hi=0.
  - divu rt=0 → hi/lo unchanged after 10 busy cycles.
- Request rules:
  - mthi rs=0x1234 with flush=1 → hi unchanged.
  - Next cycle without flush → hi=0x1234.
  - mflo with sel=010 → rd=lo in the same cycle.
- Busy and reset:
  - Second mult presented while busy → ignored; stall=1 throughout.
  - reset_n pulsed low mid-divide → busy=0, hi=lo=0 immediately.
- MDU_MADD_EN defined: hi:lo = 0:10, mult 3×4 with accum=1 → lo=22. Macro undefined, same stimulus → lo=12.
